// File: rtl/overture_io_responder.sv
// Host-side I/O partner for the Overture CPU: input FIFO feeds in_port, output FIFO captures out_port writes.
// Define OVERTURE_IO_STALL_EN to hold run_out low while an I/O instruction would hit an empty/full FIFO.
module overture_io_responder #(
  parameter int unsigned IN_DEPTH  = 16,
  parameter int unsigned OUT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         host_in_valid,
  input  logic [7:0]                   host_in_data,
  output logic                         host_in_ready,
  output logic                         host_out_valid,
  output logic [7:0]                   host_out_data,
  input  logic                         host_out_ready,
  input  logic                         run_in,
  output logic                         run_out,
  input  logic [7:0]                   cpu_instr,
  input  logic [7:0]                   cpu_out_port,
  output logic [7:0]                   cpu_in_port,
  output logic [$clog2(IN_DEPTH):0]    in_count,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic                         underflow,
  output logic                         overflow
);

  localparam int unsigned IAW = $clog2(IN_DEPTH);
  localparam int unsigned OAW = $clog2(OUT_DEPTH);
  localparam int unsigned ICW = IAW + 1;
  localparam int unsigned OCW = OAW + 1;
  localparam logic [IAW:0] IN_FULL_CNT  = ICW'(IN_DEPTH);
  localparam logic [OAW:0] OUT_FULL_CNT = OCW'(OUT_DEPTH);

  logic [7:0] in_mem  [IN_DEPTH];
  logic [7:0] out_mem [OUT_DEPTH];

  logic [IAW:0] in_wptr, in_rptr;
  logic [OAW:0] out_wptr, out_rptr;
  logic         wr_pend;
  logic         run_ok;

  logic in_empty, in_full, out_empty, out_full;
  logic is_copy, rd_io, wr_io, stall;
  logic rd_exec, wr_exec;
  logic in_push, in_pop, out_push, out_pop;

  // Occupancy from extended pointers; the extra bit separates full from empty
  assign in_count  = in_wptr - in_rptr;
  assign out_count = out_wptr - out_rptr;
  assign in_empty  = (in_count == '0);
  assign in_full   = (in_count == IN_FULL_CNT);
  assign out_empty = (out_count == '0);
  assign out_full  = (out_count == OUT_FULL_CNT);

  assign is_copy = (cpu_instr[7:6] == 2'b10);
  assign rd_io   = is_copy && (cpu_instr[5:3] == 3'd6);
  assign wr_io   = is_copy && (cpu_instr[2:0] == 3'd6);

`ifdef OVERTURE_IO_STALL_EN
  localparam logic [OAW:0] OUT_LAST_CNT = OCW'(OUT_DEPTH - 1);
  // A write still in flight will occupy the last free slot, so treat it as full
  assign stall = (rd_io && in_empty) ||
                 (wr_io && (out_full || (wr_pend && (out_count == OUT_LAST_CNT))));
`else
  assign stall = 1'b0;
`endif

  // run_ok keeps the CPU halted for the first cycle after a reset edge
  assign run_out = run_in && run_ok && !stall;
  assign rd_exec = run_out && rd_io;
  assign wr_exec = run_out && wr_io;

  assign host_in_ready  = !in_full;
  assign host_out_valid = !out_empty;
  assign cpu_in_port    = in_empty  ? 8'h00 : in_mem[in_rptr[IAW-1:0]];
  assign host_out_data  = out_empty ? 8'h00 : out_mem[out_rptr[OAW-1:0]];

  assign in_push  = host_in_valid && !in_full;
  assign in_pop   = rd_exec && !in_empty;
  assign out_pop  = host_out_valid && host_out_ready;
  // Pop frees a slot on the same edge, so a full FIFO can still accept
  assign out_push = wr_pend && (!out_full || out_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wptr   <= '0;
      in_rptr   <= '0;
      out_wptr  <= '0;
      out_rptr  <= '0;
      wr_pend   <= 1'b0;
      run_ok    <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      run_ok  <= 1'b1;
      wr_pend <= wr_exec;
      if (in_push)  in_wptr  <= in_wptr + ICW'(1);
      if (in_pop)   in_rptr  <= in_rptr + ICW'(1);
      if (out_push) out_wptr <= out_wptr + OCW'(1);
      if (out_pop)  out_rptr <= out_rptr + OCW'(1);
      if (rd_exec && in_empty) underflow <= 1'b1;
      if (wr_pend && !out_push) overflow <= 1'b1;
    end
  end

  // Storage arrays need no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wptr[IAW-1:0]]    <= host_in_data;
    if (out_push) out_mem[out_wptr[OAW-1:0]]  <= cpu_out_port;
  end

endmodule

// File: tb/tb_overture_io_responder.sv
// Self-checking bench for overture_io_responder: vector table, corner sequences and a queue-based reference model.
module tb_overture_io_responder;

  localparam int ID = 16;
  localparam int OD = 16;
  localparam logic [7:0] I_RD   = 8'b10_110_000;
  localparam logic [7:0] I_WR   = 8'b10_000_110;
  localparam logic [7:0] I_BOTH = 8'b10_110_110;
  localparam logic [7:0] I_NOP  = 8'h00;

  logic       clk = 1'b0;
  logic       reset, host_in_valid, host_in_ready, host_out_valid, host_out_ready;
  logic [7:0] host_in_data, host_out_data, cpu_instr, cpu_out_port, cpu_in_port;
  logic       run_in, run_out, underflow, overflow;
  logic [4:0] in_count, out_count;

  overture_io_responder #(.IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk(clk), .reset(reset),
    .host_in_valid(host_in_valid), .host_in_data(host_in_data), .host_in_ready(host_in_ready),
    .host_out_valid(host_out_valid), .host_out_data(host_out_data), .host_out_ready(host_out_ready),
    .run_in(run_in), .run_out(run_out), .cpu_instr(cpu_instr), .cpu_out_port(cpu_out_port),
    .cpu_in_port(cpu_in_port), .in_count(in_count), .out_count(out_count),
    .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and flags
  byte unsigned inq[$];
  byte unsigned outq[$];
  bit m_pend, m_uf, m_of, m_runok, model_ok;

  function automatic bit m_run(input bit ri, input logic [7:0] ins);
    bit rd, wr, st;
    rd = (ins[7:6] == 2'b10) && (ins[5:3] == 3'd6);
    wr = (ins[7:6] == 2'b10) && (ins[2:0] == 3'd6);
    st = 1'b0;
`ifdef OVERTURE_IO_STALL_EN
    st = (rd && inq.size() == 0) ||
         (wr && (outq.size() == OD || (m_pend && outq.size() == OD - 1)));
`endif
    return ri && m_runok && !st;
  endfunction

  task automatic model_step(input bit rst, hv, input logic [7:0] hd, input bit hr, ri,
                            input logic [7:0] ins, input logic [7:0] op);
    bit rd, wr, run, in_rdy, out_pop;
    if (rst) begin
      inq.delete(); outq.delete();
      m_pend = 0; m_uf = 0; m_of = 0; m_runok = 0;
      return;
    end
    rd = (ins[7:6] == 2'b10) && (ins[5:3] == 3'd6);
    wr = (ins[7:6] == 2'b10) && (ins[2:0] == 3'd6);
    run = m_run(ri, ins);
    in_rdy = inq.size() < ID;
    out_pop = hr && outq.size() > 0;
    if (out_pop) void'(outq.pop_front());
    if (m_pend) begin
      if (outq.size() < OD) outq.push_back(op);
      else m_of = 1;
    end
    if (run && rd) begin
      if (inq.size() == 0) m_uf = 1;
      else void'(inq.pop_front());
    end
    if (hv && in_rdy) inq.push_back(hd);
    m_pend = run && wr;
    m_runok = 1;
  endtask

  // One clock: drive, compare pre-edge against model (and optional explicit run_out), advance
  task automatic cycle(input bit rst, hv, input logic [7:0] hd, input bit hr, ri,
                       input logic [7:0] ins, input logic [7:0] op, input int exp_run);
    reset = rst; host_in_valid = hv; host_in_data = hd; host_out_ready = hr;
    run_in = ri; cpu_instr = ins; cpu_out_port = op;
    #1;
    if (model_ok) begin
      chk("m_in_count", 32'(in_count), 32'(inq.size()));
      chk("m_out_count", 32'(out_count), 32'(outq.size()));
      chk("m_host_in_ready", 32'(host_in_ready), 32'(inq.size() < ID));
      chk("m_host_out_valid", 32'(host_out_valid), 32'(outq.size() > 0));
      chk("m_host_out_data", 32'(host_out_data), 32'(outq.size() > 0 ? outq[0] : 8'h00));
      chk("m_cpu_in_port", 32'(cpu_in_port), 32'(inq.size() > 0 ? inq[0] : 8'h00));
      chk("m_underflow", 32'(underflow), 32'(m_uf));
      chk("m_overflow", 32'(overflow), 32'(m_of));
      chk("m_run_out", 32'(run_out), 32'(m_run(ri, ins)));
    end
    if (exp_run >= 0) chk("run_out", 32'(run_out), 32'(exp_run));
    model_step(rst, hv, hd, hr, ri, ins, op);
    if (rst) model_ok = 1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst, hv; logic [7:0] hd; bit hr, ri; logic [7:0] ins, op;
    int e_inc, e_outc; logic [7:0] e_cip; bit e_hov; logic [7:0] e_hod; bit e_uf, e_of;
  } vec_t;

  vec_t vt[13];

  initial begin
    model_ok = 0;
    //        rst hv hd     hr ri ins     op     inc outc cip    hov hod    uf of
    vt[0]  = '{1, 0, 8'h00, 0, 0, I_NOP,  8'h00, 0,  0,   8'h00, 0,  8'h00, 0, 0};
    vt[1]  = '{0, 0, 8'h00, 0, 0, I_NOP,  8'h00, 0,  0,   8'h00, 0,  8'h00, 0, 0};
    vt[2]  = '{0, 1, 8'h11, 0, 0, I_NOP,  8'h00, 1,  0,   8'h11, 0,  8'h00, 0, 0};
    vt[3]  = '{0, 1, 8'h22, 0, 0, I_NOP,  8'h00, 2,  0,   8'h11, 0,  8'h00, 0, 0};
    vt[4]  = '{0, 0, 8'h00, 0, 1, I_RD,   8'h00, 1,  0,   8'h22, 0,  8'h00, 0, 0};
    vt[5]  = '{0, 0, 8'h00, 0, 1, I_RD,   8'h00, 0,  0,   8'h00, 0,  8'h00, 0, 0};
    vt[6]  = '{0, 0, 8'h00, 0, 1, I_WR,   8'h00, 0,  0,   8'h00, 0,  8'h00, 0, 0};
    vt[7]  = '{0, 0, 8'h00, 0, 1, I_NOP,  8'h5A, 0,  1,   8'h00, 1,  8'h5A, 0, 0};
    vt[8]  = '{0, 0, 8'h00, 1, 1, I_NOP,  8'h00, 0,  0,   8'h00, 0,  8'h00, 0, 0};
    vt[9]  = '{0, 1, 8'hAB, 0, 1, I_NOP,  8'h00, 1,  0,   8'hAB, 0,  8'h00, 0, 0};
    vt[10] = '{0, 0, 8'h00, 0, 1, I_BOTH, 8'h00, 0,  0,   8'h00, 0,  8'h00, 0, 0};
    vt[11] = '{0, 0, 8'h00, 0, 1, I_NOP,  8'hAB, 0,  1,   8'h00, 1,  8'hAB, 0, 0};
    vt[12] = '{0, 0, 8'h00, 1, 0, I_NOP,  8'h00, 0,  0,   8'h00, 0,  8'h00, 0, 0};

    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].rst, vt[i].hv, vt[i].hd, vt[i].hr, vt[i].ri, vt[i].ins, vt[i].op, -1);
      chk($sformatf("v%0d_in_count", i), 32'(in_count), 32'(vt[i].e_inc));
      chk($sformatf("v%0d_out_count", i), 32'(out_count), 32'(vt[i].e_outc));
      chk($sformatf("v%0d_cpu_in_port", i), 32'(cpu_in_port), 32'(vt[i].e_cip));
      chk($sformatf("v%0d_host_out_valid", i), 32'(host_out_valid), 32'(vt[i].e_hov));
      chk($sformatf("v%0d_host_out_data", i), 32'(host_out_data), 32'(vt[i].e_hod));
      chk($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vt[i].e_uf));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].e_of));
    end

    // Read with empty input FIFO
    cycle(1, 0, 0, 0, 0, I_NOP, 0, -1);
    cycle(0, 0, 0, 0, 0, I_NOP, 0, -1);
`ifdef OVERTURE_IO_STALL_EN
    cycle(0, 0, 8'h00, 0, 1, I_RD, 0, 0);
    cycle(0, 1, 8'h33, 0, 1, I_RD, 0, 0);
    chk("stall_rd_in_count", 32'(in_count), 32'd1);
    cycle(0, 0, 8'h00, 0, 1, I_RD, 0, 1);
    chk("stall_rd_consumed", 32'(in_count), 32'd0);
    chk("stall_rd_underflow", 32'(underflow), 32'd0);
`else
    cycle(0, 0, 8'h00, 0, 1, I_RD, 0, 1);
    chk("empty_rd_underflow", 32'(underflow), 32'd1);
    chk("empty_rd_in_count", 32'(in_count), 32'd0);
    chk("empty_rd_cpu_in_port", 32'(cpu_in_port), 32'h00);
`endif

    // Fill output FIFO, then write 8'hEE into a full FIFO
    cycle(1, 0, 0, 0, 0, I_NOP, 0, -1);
    cycle(0, 0, 0, 0, 0, I_NOP, 0, -1);
    for (int i = 0; i < OD; i++) begin
      cycle(0, 0, 0, 0, 1, I_WR, 0, 1);
      cycle(0, 0, 0, 0, 1, I_NOP, 8'(i + 1), -1);
    end
    chk("fill_out_count", 32'(out_count), 32'(OD));
`ifdef OVERTURE_IO_STALL_EN
    cycle(0, 0, 0, 0, 1, I_WR, 0, 0);
    cycle(0, 0, 0, 1, 1, I_WR, 0, 0);
    cycle(0, 0, 0, 0, 1, I_WR, 0, 1);
    cycle(0, 0, 0, 0, 1, I_NOP, 8'hEE, -1);
    chk("stall_wr_out_count", 32'(out_count), 32'(OD));
    chk("stall_wr_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < OD - 1; i++) cycle(0, 0, 0, 1, 0, I_NOP, 0, -1);
    chk("stall_wr_tail", 32'(host_out_data), 32'hEE);
`else
    cycle(0, 0, 0, 0, 1, I_WR, 0, 1);
    cycle(0, 0, 0, 0, 1, I_NOP, 8'hEE, -1);
    chk("full_wr_overflow", 32'(overflow), 32'd1);
    chk("full_wr_out_count", 32'(out_count), 32'(OD));
    chk("full_wr_head", 32'(host_out_data), 32'h01);
`endif

    // Mid-stream reset with both FIFOs half full
    cycle(1, 0, 0, 0, 0, I_NOP, 0, -1);
    cycle(0, 0, 0, 0, 0, I_NOP, 0, -1);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 8'(8'h40 + i), 0, 1, I_WR, 0, -1);
      cycle(0, 0, 0, 0, 1, I_NOP, 8'(8'h80 + i), -1);
    end
    chk("half_in_count", 32'(in_count), 32'd8);
    chk("half_out_count", 32'(out_count), 32'd8);
    cycle(1, 1, 8'h99, 0, 1, I_BOTH, 8'h77, -1);
    cycle(0, 0, 0, 0, 1, I_NOP, 0, 0);
    chk("rst_in_count", 32'(in_count), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_host_in_ready", 32'(host_in_ready), 32'd1);
    chk("rst_host_out_valid", 32'(host_out_valid), 32'd0);
    chk("rst_host_out_data", 32'(host_out_data), 32'h00);

    // Random traffic against the model, alternating drain-heavy and fill-heavy phases
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ins;
      bit hr;
      case ($urandom_range(0, 4))
        0: ins = {5'b10_110, 3'($urandom_range(0, 7))};
        1: ins = {2'b10, 3'($urandom_range(0, 7)), 3'd6};
        2: ins = I_BOTH;
        default: ins = 8'($urandom);
      endcase
      hr = ($urandom_range(0, 99) < (((i / 300) % 2) != 0 ? 80 : 15));
      cycle($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1, 8'($urandom), hr,
            $urandom_range(0, 9) != 0, ins, 8'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
